// File: rtl/alu_pkg.sv
// Shared encodings for the pipelined ALU: opcodes, shift types, NZCV layout
// and the multiplier state type.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_ADC = 4'b0010;
    localparam logic [3:0] OP_SBC = 4'b0011;
    localparam logic [3:0] OP_RSB = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_ORR = 4'b0110;
    localparam logic [3:0] OP_EOR = 4'b0111;
    localparam logic [3:0] OP_BIC = 4'b1000;
    localparam logic [3:0] OP_MVN = 4'b1001;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_TST = 4'b1011;
    localparam logic [3:0] OP_MVI = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1101;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    typedef enum logic [1:0] {
        MUL_IDLE,
        MUL_RUN,
        MUL_DONE
    } mul_state_e;

    // Ops whose shifted operand may be inverted and whose C comes from the shifter.
    function automatic logic isLogicOp(input logic [3:0] op);
        return (op == OP_AND) || (op == OP_ORR) || (op == OP_EOR) || (op == OP_BIC) ||
               (op == OP_MVN) || (op == OP_TST) || (op == OP_MVI);
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter for operand2 with carry-out; a zero distance
// passes the value through and forwards the incoming carry.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]   value_i,
    input  logic [1:0]         shiftType_i,
    input  logic [SHAMT_W-1:0] shiftAmt_i,
    input  logic               carry_i,
    output logic [WIDTH-1:0]   result_o,
    output logic               carry_o
);

    logic [SHAMT_W-1:0] negAmt;
    logic [WIDTH-1:0]   rorValue;

    // Modulo-WIDTH wrap makes this WIDTH-amt for every non-zero distance.
    assign negAmt   = SHAMT_W'(WIDTH) - shiftAmt_i;
    assign rorValue = (value_i >> shiftAmt_i) | (value_i << negAmt);

    always_comb begin
        result_o = value_i;
        carry_o  = carry_i;
        if (shiftAmt_i != '0) begin
            case (shiftType_i)
                SH_LSL: begin
                    result_o = value_i << shiftAmt_i;
                    carry_o  = value_i[negAmt];
                end
                SH_LSR: begin
                    result_o = value_i >> shiftAmt_i;
                    carry_o  = value_i[shiftAmt_i - 1'b1];
                end
                SH_ASR: begin
                    result_o = $signed(value_i) >>> shiftAmt_i;
                    carry_o  = value_i[shiftAmt_i - 1'b1];
                end
                default: begin
                    result_o = rorValue;
                    carry_o  = rorValue[WIDTH-1];
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU: shift/S1 register, execute, output register with NZCV flags.
// Define ALU_PIPE_MUL_EN to build the iterative shift-add multiplier for op 1101.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int         WIDTH      = 32,
    parameter logic [3:0] FLAG_RESET = 4'b0000,
    localparam int        SHAMT_W    = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   operand1,
    input  logic [WIDTH-1:0]   operand2,
    input  logic [3:0]         alu_op,
    input  logic [1:0]         shift_type,
    input  logic [SHAMT_W-1:0] shift_amt,
    input  logic               alu_invert_operand2,
    input  logic               set_flags,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   alu_result,
    output logic               zero_flag,
    output logic               negative_flag,
    output logic               carry_flag,
    output logic               overflow_flag,
    output logic               busy
);

    logic             outFree;
    logic             accept;
    logic             s1Adv;
    logic [WIDTH-1:0] shifted;
    logic             shiftCarry;
    logic [WIDTH-1:0] op2e;

    logic             s1Valid_q;
    logic [WIDTH-1:0] s1Op1_q;
    logic [WIDTH-1:0] s1Op2_q;
    logic             s1ShCarry_q;
    logic             s1AmtZero_q;
    logic [3:0]       s1Op_q;
    logic             s1SetFlags_q;

    logic             outValid_q;
    logic [WIDTH-1:0] aluResult_q;
    flags_t           flags_q;
    flags_t           flags_d;
    logic [WIDTH-1:0] aluResult_d;

    logic [WIDTH-1:0] addX;
    logic [WIDTH-1:0] addY;
    logic             addCin;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] logicRes;
    logic             isArith;
    logic             isLogic;
    logic             flagWrite;
    logic             shCarryEff;

    alu_shifter #(.WIDTH(WIDTH)) uShifter (
        .value_i    (operand2),
        .shiftType_i(shift_type),
        .shiftAmt_i (shift_amt),
        .carry_i    (flags_q.c),
        .result_o   (shifted),
        .carry_o    (shiftCarry)
    );

    assign op2e     = (alu_invert_operand2 && isLogicOp(alu_op)) ? ~shifted : shifted;
    assign outFree  = !outValid_q || out_ready;
    assign in_ready = !s1Valid_q || s1Adv;
    assign accept   = in_valid && in_ready;

`ifdef ALU_PIPE_MUL_EN
    mul_state_e         mulState_q;
    logic [SHAMT_W-1:0] mulCnt_q;
    logic [WIDTH-1:0]   mulAcc_q;
    logic [WIDTH-1:0]   mulCand_q;
    logic [WIDTH-1:0]   mulPlier_q;
    logic               busy_q;

    // A MUL in S1 only leaves once the product is ready and the output slot is free.
    assign s1Adv = s1Valid_q && outFree && ((s1Op_q != OP_MUL) || (mulState_q == MUL_DONE));
    assign busy  = busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mulState_q <= MUL_IDLE;
            mulCnt_q   <= '0;
            mulAcc_q   <= '0;
            mulCand_q  <= '0;
            mulPlier_q <= '0;
            busy_q     <= 1'b0;
        end else if (accept && (alu_op == OP_MUL)) begin
            mulState_q <= MUL_RUN;
            mulCnt_q   <= '0;
            mulAcc_q   <= '0;
            mulCand_q  <= operand1;
            mulPlier_q <= op2e;
            busy_q     <= 1'b1;
        end else begin
            case (mulState_q)
                MUL_RUN: begin
                    if (mulPlier_q[0]) begin
                        mulAcc_q <= mulAcc_q + mulCand_q;
                    end
                    mulCand_q  <= mulCand_q << 1;
                    mulPlier_q <= mulPlier_q >> 1;
                    mulCnt_q   <= mulCnt_q + 1'b1;
                    if (mulCnt_q == SHAMT_W'(WIDTH - 1)) begin
                        mulState_q <= MUL_DONE;
                    end
                end
                MUL_DONE: begin
                    if (s1Adv) begin
                        mulState_q <= MUL_IDLE;
                        busy_q     <= 1'b0;
                    end
                end
                default: begin
                    mulState_q <= MUL_IDLE;
                end
            endcase
        end
    end
`else
    assign s1Adv = s1Valid_q && outFree;
    assign busy  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Valid_q    <= 1'b0;
            s1Op1_q      <= '0;
            s1Op2_q      <= '0;
            s1ShCarry_q  <= 1'b0;
            s1AmtZero_q  <= 1'b0;
            s1Op_q       <= OP_ADD;
            s1SetFlags_q <= 1'b0;
        end else if (accept) begin
            s1Valid_q    <= 1'b1;
            s1Op1_q      <= operand1;
            s1Op2_q      <= op2e;
            s1ShCarry_q  <= shiftCarry;
            s1AmtZero_q  <= (shift_amt == '0);
            s1Op_q       <= alu_op;
            s1SetFlags_q <= set_flags;
        end else if (s1Adv) begin
            s1Valid_q <= 1'b0;
        end
    end

    // Operand selection for the shared adder; subtract forms add the complement.
    always_comb begin
        addX     = s1Op1_q;
        addY     = s1Op2_q;
        addCin   = 1'b0;
        logicRes = s1Op2_q;
        isArith  = 1'b0;
        isLogic  = 1'b0;
        case (s1Op_q)
            OP_ADD: isArith = 1'b1;
            OP_SUB, OP_CMP: begin
                addY    = ~s1Op2_q;
                addCin  = 1'b1;
                isArith = 1'b1;
            end
            OP_ADC: begin
                addCin  = flags_q.c;
                isArith = 1'b1;
            end
            OP_SBC: begin
                addY    = ~s1Op2_q;
                addCin  = flags_q.c;
                isArith = 1'b1;
            end
            OP_RSB: begin
                addX    = s1Op2_q;
                addY    = ~s1Op1_q;
                addCin  = 1'b1;
                isArith = 1'b1;
            end
            OP_AND, OP_TST, OP_BIC: begin
                logicRes = s1Op1_q & s1Op2_q;
                isLogic  = 1'b1;
            end
            OP_ORR: begin
                logicRes = s1Op1_q | s1Op2_q;
                isLogic  = 1'b1;
            end
            OP_EOR: begin
                logicRes = s1Op1_q ^ s1Op2_q;
                isLogic  = 1'b1;
            end
            OP_MVN, OP_MVI: isLogic = 1'b1;
            default: ;
        endcase
    end

    assign sum        = {1'b0, addX} + {1'b0, addY} + {{WIDTH{1'b0}}, addCin};
    assign flagWrite  = s1SetFlags_q || (s1Op_q == OP_CMP) || (s1Op_q == OP_TST);
    // Zero-distance shifts take C as it stands when the op executes, not when it was accepted.
    assign shCarryEff = s1AmtZero_q ? flags_q.c : s1ShCarry_q;

    always_comb begin
        aluResult_d = '0;
        flags_d     = flags_q;
        if (isArith) begin
            aluResult_d = sum[WIDTH-1:0];
            if (flagWrite) begin
                flags_d.n = sum[WIDTH-1];
                flags_d.z = (sum[WIDTH-1:0] == '0);
                flags_d.c = sum[WIDTH];
                flags_d.v = (addX[WIDTH-1] == addY[WIDTH-1]) && (sum[WIDTH-1] != addX[WIDTH-1]);
            end
        end else if (isLogic) begin
            aluResult_d = logicRes;
            if (flagWrite) begin
                flags_d.n = logicRes[WIDTH-1];
                flags_d.z = (logicRes == '0);
                flags_d.c = shCarryEff;
            end
        end
`ifdef ALU_PIPE_MUL_EN
        else if (s1Op_q == OP_MUL) begin
            aluResult_d = mulAcc_q;
            if (s1SetFlags_q) begin
                flags_d.n = mulAcc_q[WIDTH-1];
                flags_d.z = (mulAcc_q == '0);
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outValid_q  <= 1'b0;
            aluResult_q <= '0;
            flags_q     <= flags_t'(FLAG_RESET);
        end else if (s1Adv) begin
            outValid_q  <= 1'b1;
            aluResult_q <= aluResult_d;
            flags_q     <= flags_d;
        end else if (out_ready) begin
            outValid_q <= 1'b0;
        end
    end

    assign out_valid     = outValid_q;
    assign alu_result    = aluResult_q;
    assign negative_flag = flags_q[FLAG_N];
    assign zero_flag     = flags_q[FLAG_Z];
    assign carry_flag    = flags_q[FLAG_C];
    assign overflow_flag = flags_q[FLAG_V];

endmodule

// File: tb/tb_alu_pipe.sv
// Directed scoreboard bench for alu_pipe (WIDTH=32); the multiplier section
// follows ALU_PIPE_MUL_EN.
module tb_alu_pipe;

    localparam logic [3:0] T_ADD = 4'b0000, T_SUB = 4'b0001, T_ADC = 4'b0010, T_SBC = 4'b0011;
    localparam logic [3:0] T_RSB = 4'b0100, T_AND = 4'b0101, T_ORR = 4'b0110, T_EOR = 4'b0111;
    localparam logic [3:0] T_BIC = 4'b1000, T_CMP = 4'b1010, T_TST = 4'b1011, T_MVI = 4'b1100;
    localparam logic [3:0] T_MUL = 4'b1101, T_RSV = 4'b1110;
    localparam logic [1:0] LSL = 2'b00, LSR = 2'b01, ASR = 2'b10, ROR = 2'b11;
`ifdef ALU_PIPE_MUL_EN
    localparam logic [3:0] F_AFTER_MUL = 4'b0010;
`else
    localparam logic [3:0] F_AFTER_MUL = 4'b1010;
`endif

    logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] operand1, operand2, alu_result;
    logic [3:0]  alu_op;
    logic [1:0]  shift_type;
    logic [4:0]  shift_amt;
    logic        alu_invert_operand2, set_flags;
    logic        zero_flag, negative_flag, carry_flag, overflow_flag, busy;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  nzcv;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;

    alu_pipe #(.WIDTH(32), .FLAG_RESET(4'b0000)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .operand1(operand1), .operand2(operand2), .alu_op(alu_op),
        .shift_type(shift_type), .shift_amt(shift_amt),
        .alu_invert_operand2(alu_invert_operand2), .set_flags(set_flags),
        .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
        .zero_flag(zero_flag), .negative_flag(negative_flag),
        .carry_flag(carry_flag), .overflow_flag(overflow_flag), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called one half-cycle before the edge that completes an output handshake.
    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL unexpected output: observed 0x%08h expected none", alu_result);
        end else begin
            e = sb.pop_front();
            checkVal($sformatf("op%0d result", e.id), alu_result, e.res);
            checkVal($sformatf("op%0d nzcv", e.id),
                     {28'd0, negative_flag, zero_flag, carry_flag, overflow_flag}, {28'd0, e.nzcv});
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) checkOutput();
    end

    // Entered and left at 1ns after a rising edge; acc is the cycle of the accepting edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [1:0] st, input logic [4:0] amt, input logic inv,
                                 input logic sf, input logic [31:0] expRes, input logic [3:0] expNzcv,
                                 input int id, output int acc);
        exp_t e;
        int   waited;
        in_valid = 1'b1;
        alu_op = op;
        operand1 = a;
        operand2 = b;
        shift_type = st;
        shift_amt = amt;
        alu_invert_operand2 = inv;
        set_flags = sf;
        e.res = expRes;
        e.nzcv = expNzcv;
        e.id = id;
        sb.push_back(e);
        waited = 0;
        acc = -1;
        forever begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            waited++;
            if (waited > 100) break;
        end
        if (waited > 100) begin
            checks++;
            errors++;
            $error("[TB] FAIL op%0d accept: observed no in_ready expected accept within 100 cycles", id);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            acc = cycle;
            in_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int acc, accB, mulAcc, addAcc, n;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        operand1 = '0;
        operand2 = '0;
        alu_op = '0;
        shift_type = '0;
        shift_amt = '0;
        alu_invert_operand2 = 1'b0;
        set_flags = 1'b0;
        idle(3);
        checkVal("reset out_valid", out_valid, 0);
        checkVal("reset alu_result", alu_result, 0);
        checkVal("reset nzcv", {negative_flag, zero_flag, carry_flag, overflow_flag}, 0);
        checkVal("reset busy", busy, 0);
        rst = 1'b0;
        idle(1);
        checkVal("in_ready after reset", in_ready, 1);

        $display("[TB] ADD overflow and latency");
        applyStimulus(T_ADD, 32'h7FFFFFFF, 32'h1, LSL, 5'd0, 1'b0, 1'b1, 32'h80000000, 4'b1001, 1, acc);
        checkVal("out_valid at accept", out_valid, 0);
        idle(1);
        checkVal("out_valid one cycle after accept", out_valid, 1);
        idle(2);

        $display("[TB] SUB then ADC back-to-back");
        applyStimulus(T_SUB, 32'd30, 32'd10, LSL, 5'd0, 1'b0, 1'b1, 32'd20, 4'b0010, 2, acc);
        applyStimulus(T_ADC, 32'd5, 32'd3, LSL, 5'd0, 1'b0, 1'b1, 32'd9, 4'b0000, 3, accB);
        checkVal("back-to-back accept spacing", accB - acc, 1);

        $display("[TB] shifter cases");
        applyStimulus(T_MVI, 32'd0, 32'h12345678, ROR, 5'd4, 1'b0, 1'b1, 32'h81234567, 4'b1010, 4, acc);
        applyStimulus(T_MVI, 32'd0, 32'h80000000, ASR, 5'd1, 1'b0, 1'b0, 32'hC0000000, 4'b1010, 5, acc);
        applyStimulus(T_AND, 32'hFF, 32'h0F, LSL, 5'd0, 1'b0, 1'b1, 32'h0F, 4'b0010, 6, acc);
        applyStimulus(T_MVI, 32'd0, 32'h1, LSR, 5'd1, 1'b0, 1'b1, 32'h0, 4'b0110, 7, acc);

        $display("[TB] compare, carry ops, logic ops");
        applyStimulus(T_CMP, 32'd5, 32'd7, LSL, 5'd0, 1'b0, 1'b0, 32'hFFFFFFFE, 4'b1000, 8, acc);
        applyStimulus(T_SBC, 32'd10, 32'd3, LSL, 5'd0, 1'b0, 1'b1, 32'd6, 4'b0010, 9, acc);
        applyStimulus(T_RSB, 32'd3, 32'd10, LSL, 5'd0, 1'b0, 1'b1, 32'd7, 4'b0010, 10, acc);
        applyStimulus(T_BIC, 32'hF0F0, 32'h00FF, LSL, 5'd0, 1'b1, 1'b0, 32'hF000, 4'b0010, 11, acc);
        applyStimulus(T_ADD, 32'd1, 32'd2, LSL, 5'd0, 1'b1, 1'b0, 32'd3, 4'b0010, 12, acc);
        applyStimulus(T_EOR, 32'hFFFF0000, 32'hFFFF0000, LSL, 5'd0, 1'b0, 1'b1, 32'h0, 4'b0110, 13, acc);
        applyStimulus(T_TST, 32'h80000000, 32'h80000000, LSL, 5'd0, 1'b0, 1'b0, 32'h80000000, 4'b1010, 14, acc);
        applyStimulus(T_RSV, 32'd5, 32'd5, LSL, 5'd0, 1'b0, 1'b1, 32'h0, 4'b1010, 15, acc);
        idle(3);

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(T_ADD, 32'd1, 32'd1, LSL, 5'd0, 1'b0, 1'b0, 32'd2, 4'b1010, 16, acc);
        applyStimulus(T_SUB, 32'd9, 32'd4, LSL, 5'd0, 1'b0, 1'b0, 32'd5, 4'b1010, 17, acc);
        fork
            applyStimulus(T_ORR, 32'h10, 32'h01, LSL, 5'd0, 1'b0, 1'b0, 32'h11, 4'b1010, 18, acc);
            begin
                checkVal("in_ready with S1 full", in_ready, 0);
                checkVal("stall alu_result", alu_result, 32'd2);
                idle(1);
                checkVal("stall out_valid", out_valid, 1);
                checkVal("stall alu_result held", alu_result, 32'd2);
                checkVal("in_ready still low", in_ready, 0);
                idle(1);
                checkVal("stall alu_result held 2", alu_result, 32'd2);
                out_ready = 1'b1;
            end
        join
        idle(4);

`ifdef ALU_PIPE_MUL_EN
        $display("[TB] multiplier");
        applyStimulus(T_MUL, 32'h1234, 32'h10, LSL, 5'd0, 1'b0, 1'b1, 32'h12340, 4'b0010, 20, mulAcc);
        fork
            applyStimulus(T_ADD, 32'd2, 32'd3, LSL, 5'd0, 1'b0, 1'b0, 32'd5, 4'b0010, 21, addAcc);
            begin
                n = 0;
                while (out_valid !== 1'b1 && n < 60) begin
                    checkVal("busy during MUL", busy, 1);
                    idle(1);
                    n++;
                end
                checkVal("MUL latency", cycle - mulAcc, 33);
            end
        join
        checkVal("ADD accepted when S1 frees", addAcc - mulAcc, 33);
        idle(3);
`else
        $display("[TB] op 1101 reserved");
        applyStimulus(T_MUL, 32'h1234, 32'h10, LSL, 5'd0, 1'b0, 1'b1, 32'h0, 4'b1010, 20, mulAcc);
        checkVal("busy without multiplier", busy, 0);
        idle(3);
`endif

        $display("[TB] reset mid-operation");
        out_ready = 1'b0;
        applyStimulus(T_ADD, 32'd1, 32'd1, LSL, 5'd0, 1'b0, 1'b0, 32'd2, F_AFTER_MUL, 30, acc);
`ifdef ALU_PIPE_MUL_EN
        applyStimulus(T_MUL, 32'd3, 32'd4, LSL, 5'd0, 1'b0, 1'b1, 32'd12, 4'b0010, 31, acc);
        idle(4);
        checkVal("busy before reset", busy, 1);
`else
        idle(4);
`endif
        checkVal("out_valid before reset", out_valid, 1);
        rst = 1'b1;
        #1;
        checkVal("mid-op reset out_valid", out_valid, 0);
        checkVal("mid-op reset busy", busy, 0);
        checkVal("mid-op reset nzcv", {negative_flag, zero_flag, carry_flag, overflow_flag}, 0);
        checkVal("mid-op reset alu_result", alu_result, 0);
        sb.delete();
        idle(1);
        rst = 1'b0;
        #1;
        checkVal("in_ready after mid-op reset", in_ready, 1);
        out_ready = 1'b1;
        idle(1);
        applyStimulus(T_ADD, 32'd10, 32'd20, LSL, 5'd0, 1'b0, 1'b1, 32'd30, 4'b0000, 40, acc);
        idle(3);
        checkVal("scoreboard drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
